// File: rtl/easyaxi_pkg.sv
// Shared EasyAXI definitions: arbiter state encoding and index-width helper.
// No logic of its own.
// No flow control.
package easyaxi_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/easyaxi_order_fifo.sv
// In-order FIFO of granted requester indices; head data is combinational.
// Push visible at the head one cycle after the push edge; full/empty registered-count based.
// Pushes while full are ignored unless a pop frees the slot in the same cycle.
module easyaxi_order_fifo
#(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 8
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  wr_en;
    logic                  rd_en;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/easyaxi_ar_arbiter.sv
// Round-robin AR arbiter onto one master port; R bursts steered back in issue order.
// Grant cycle N -> m_arvalid from N+1; one burst per 2 cycles; R steering is combinational.
// Captures stall while the outstanding FIFO is full; R beats stall while it is empty.
// EASYAXI_AR_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module easyaxi_ar_arbiter
    import easyaxi_pkg::*;
#(
    parameter int REQ_NUM    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int OST_DEPTH  = 8
)
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_NUM-1:0]              req_arvalid,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]   req_araddr,
    input  logic [REQ_NUM*LEN_WIDTH-1:0]    req_arlen,
    output logic [REQ_NUM-1:0]              req_arready,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    output logic [ADDR_WIDTH-1:0]           m_araddr,
    output logic [LEN_WIDTH-1:0]            m_arlen,
    input  logic                            m_rvalid,
    input  logic                            m_rlast,
    output logic                            m_rready,
    output logic [REQ_NUM-1:0]              req_rvalid,
    input  logic [REQ_NUM-1:0]              req_rready,
    output logic                            ost_full
);
    localparam int IDX_W = idx_width(REQ_NUM);

    arb_state_e             state;
    arb_state_e             state_nxt;
    logic                   capture;
    logic                   ar_hs;
    logic                   r_pop;
    logic                   fifo_empty;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       head_idx;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       grant_ofs;
    logic [REQ_NUM-1:0]     rot_req;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;

`ifdef EASYAXI_AR_ARB_FIXED_PRIO_EN
    assign rot_req   = req_arvalid;
    assign grant_idx = grant_ofs;
`else
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W:0]   grant_sum;

    // Rotate so that bit 0 is the requester at rr_ptr; the offset is added back below.
    assign rot_req   = REQ_NUM'({req_arvalid, req_arvalid} >> rr_ptr);
    assign grant_sum = {1'b0, rr_ptr} + {1'b0, grant_ofs};
    assign grant_idx = (grant_sum >= (IDX_W+1)'(REQ_NUM))
                     ? IDX_W'(grant_sum - (IDX_W+1)'(REQ_NUM))
                     : grant_sum[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (ar_hs) begin
            rr_ptr <= (win_idx == IDX_W'(REQ_NUM-1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        grant_ofs = '0;
        for (int k = REQ_NUM-1; k >= 0; k--) begin
            if (rot_req[k]) begin
                grant_ofs = IDX_W'(k);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = req_arlen[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ar_hs     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if ((|req_arvalid) && !ost_full) begin
                    capture   = 1'b1;
                    state_nxt = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (m_arready) begin
                    ar_hs     = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_araddr <= '0;
            m_arlen  <= '0;
            win_idx  <= '0;
        end else if (capture) begin
            m_araddr <= sel_addr;
            m_arlen  <= sel_len;
            win_idx  <= grant_idx;
        end
    end

    assign req_arready = capture ? (REQ_NUM'(1) << grant_idx) : '0;
    assign m_arvalid   = (state == ARB_HOLD);

    // A HOLD always owns a free slot: capture was only allowed while not full.
    easyaxi_order_fifo #(
        .DATA_WIDTH (IDX_W),
        .DEPTH      (OST_DEPTH)
    ) u_order_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ar_hs),
        .din   (win_idx),
        .pop   (r_pop),
        .dout  (head_idx),
        .empty (fifo_empty),
        .full  (ost_full)
    );

    assign m_rready   = !fifo_empty && req_rready[head_idx];
    assign req_rvalid = fifo_empty ? '0 : ({{(REQ_NUM-1){1'b0}}, m_rvalid} << head_idx);
    assign r_pop      = m_rvalid && m_rready && m_rlast;

endmodule

// File: tb/tb_easyaxi_ar_arbiter.sv
// Bench for easyaxi_ar_arbiter: queue-based reference model compared every negedge,
// plus directed scenarios with literal expectations.
module tb_easyaxi_ar_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int OST = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_arvalid;
    logic [N*AW-1:0] req_araddr;
    logic [N*LW-1:0] req_arlen;
    logic [N-1:0]    req_arready;
    logic            m_arvalid;
    logic            m_arready;
    logic [AW-1:0]   m_araddr;
    logic [LW-1:0]   m_arlen;
    logic            m_rvalid;
    logic            m_rlast;
    logic            m_rready;
    logic [N-1:0]    req_rvalid;
    logic [N-1:0]    req_rready;
    logic            ost_full;

    always #5 clk = ~clk;

    easyaxi_ar_arbiter #(
        .REQ_NUM(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .OST_DEPTH(OST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arready(req_arready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .ost_full(ost_full)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: one pending AR plus a queue of outstanding bursts.
    bit            mdl_hold;
    int            mdl_idx;
    logic [AW-1:0] mdl_addr;
    logic [LW-1:0] mdl_len;
    int            mdl_rr;
    int            q_idx[$];
    int            q_len[$];
    int            grant_log[$];
    int            grant_cyc[$];
    int            beat_log[$];
    int            cyc = 0;

    function automatic int mdl_winner();
        int start;
        int j;
`ifdef EASYAXI_AR_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = mdl_rr;
`endif
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (req_arvalid[j]) return j;
        end
        return -1;
    endfunction

    initial begin
        mdl_hold = 0;
        mdl_idx  = 0;
        mdl_addr = '0;
        mdl_len  = '0;
        mdl_rr   = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mdl_hold = 0;
                mdl_rr   = 0;
                q_idx.delete();
                q_len.delete();
            end else begin
                int  w;
                bit  do_pop;
                bit  do_push;
                bit  do_grant;
                cyc++;
                w        = mdl_winner();
                do_pop   = (q_idx.size() > 0) && m_rvalid && req_rready[q_idx[0]] && m_rlast;
                do_push  = mdl_hold && m_arready;
                do_grant = !mdl_hold && (w >= 0) && (q_idx.size() < OST);
                if (do_pop) begin
                    void'(q_idx.pop_front());
                    void'(q_len.pop_front());
                end
                if (do_push) begin
                    q_idx.push_back(mdl_idx);
                    q_len.push_back(int'(mdl_len));
                    mdl_rr   = (mdl_idx + 1) % N;
                    mdl_hold = 0;
                end
                if (do_grant) begin
                    mdl_hold = 1;
                    mdl_idx  = w;
                    mdl_addr = req_araddr[w*AW +: AW];
                    mdl_len  = req_arlen[w*LW +: LW];
                end
            end
        end
    end

    // Compare process: every negedge out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                int           w;
                int           h;
                logic [N-1:0] exp_ardy;
                logic [N-1:0] exp_rv;
                logic         exp_rr;
                w = mdl_winner();
                exp_ardy = (!mdl_hold && w >= 0 && q_idx.size() < OST) ? (N'(1) << w) : '0;
                chk("req_arready", req_arready, exp_ardy);
                chk("m_arvalid", m_arvalid, mdl_hold);
                if (mdl_hold) begin
                    chk("m_araddr", m_araddr, mdl_addr);
                    chk("m_arlen", m_arlen, mdl_len);
                end
                if (q_idx.size() == 0) begin
                    exp_rv = '0;
                    exp_rr = 1'b0;
                end else begin
                    h = q_idx[0];
                    exp_rv = m_rvalid ? (N'(1) << h) : '0;
                    exp_rr = req_rready[h];
                end
                chk("req_rvalid", req_rvalid, exp_rv);
                chk("m_rready", m_rready, exp_rr);
                chk("ost_full", ost_full, q_idx.size() == OST);
                for (int i = 0; i < N; i++) begin
                    if (req_arready[i]) begin
                        grant_log.push_back(i);
                        grant_cyc.push_back(cyc);
                    end
                    if (req_rvalid[i] && req_rready[i]) beat_log.push_back(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (limit 200000)");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_araddr[i*AW +: AW] = a;
        req_arlen[i*LW +: LW]  = l;
    endtask

    task automatic drain_head();
        int len;
        if (q_len.size() == 0) return;
        len = q_len[0];
        for (int b = 0; b <= len; b++) begin
            m_rvalid = 1'b1;
            m_rlast  = (b == len);
            step(1);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic drain_all();
        int guard = 0;
        while (q_idx.size() > 0 && guard < OST + 2) begin
            drain_head();
            guard++;
        end
    endtask

    task automatic issue_one(input int i);
        int n0 = grant_log.size();
        int t  = 0;
        req_arvalid[i] = 1'b1;
        while (grant_log.size() == n0 && t < 20) begin
            step(1);
            t++;
        end
        chk("issue_granted", grant_log.size(), n0 + 1);
        if (grant_log.size() > n0) chk("issue_idx", grant_log[grant_log.size()-1], i);
        req_arvalid[i] = 1'b0;
        step(1);
    endtask

    initial begin
        int base;
        int exp_beats[6];
        int exp_pri[5];
        req_arvalid = '0;
        req_araddr  = '0;
        req_arlen   = '0;
        m_arready   = 1'b0;
        m_rvalid    = 1'b0;
        m_rlast     = 1'b0;
        req_rready  = '1;
        for (int i = 0; i < N; i++) set_req(i, 32'h1000_0000 + 32'(i) * 32'h100, LW'(i));

        // Reset state
        step(2);
        chk("rst_req_arready", req_arready, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_req_rvalid", req_rvalid, 0);
        chk("rst_ost_full", ost_full, 0);
        rst_n = 1'b1;
        step(1);

        // Round-robin fairness: all four requesting
        base = grant_log.size();
        m_arready   = 1'b1;
        req_arvalid = 4'b1111;
        step(10);
        req_arvalid = '0;
        chk("rr_grant_count", grant_log.size() - base, 5);
        if (grant_log.size() >= base + 5) begin
            chk("rr_order0", grant_log[base+0], 0);
            chk("rr_order1", grant_log[base+1], 1);
            chk("rr_order2", grant_log[base+2], 2);
            chk("rr_order3", grant_log[base+3], 3);
            chk("rr_order4", grant_log[base+4], 0);
            for (int k = 1; k < 5; k++)
                chk("rr_grant_gap", grant_cyc[base+k] - grant_cyc[base+k-1], 2);
        end
        chk("rr_last_addr", m_araddr, 32'h1000_0000);
        drain_all();

        // Backpressure: 2 held in HOLD while 1 waits
        base = grant_log.size();
        m_arready = 1'b0;
        req_arvalid = 4'b0100;
        step(1);
        req_arvalid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            chk("bp_arvalid", m_arvalid, 1);
            chk("bp_araddr", m_araddr, 32'h1000_0200);
            chk("bp_arlen", m_arlen, 2);
            chk("bp_no_grant", req_arready, 0);
            step(1);
        end
        chk("bp_grants", grant_log.size() - base, 1);
        m_arready = 1'b1;
        step(1);
        chk("bp_one_push", q_idx.size(), 1);
        step(1);
        req_arvalid = '0;
        step(1);
        chk("bp_next_winner", grant_log[grant_log.size()-1], 1);
        drain_all();

        // Outstanding limit: rr now at 2
        base = grant_log.size();
        req_arvalid = 4'b1111;
        step(16);
        chk("ost_full_set", ost_full, 1);
        chk("ost_grants", grant_log.size() - base, 8);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("ost_blocked", req_arready, 0);
        end
        chk("ost_still_8", grant_log.size() - base, 8);
        drain_head();
        chk("ost_full_clear", ost_full, 0);
        chk("ost_ninth_grant", req_arready, 4'b0100);
        step(1);
        req_arvalid = '0;
        step(1);
        chk("ost_full_again", ost_full, 1);
        drain_all();

        // In-order steering with a stalled requester
        set_req(2, 32'h2000_0002, 8'd1);
        set_req(0, 32'h2000_0000, 8'd0);
        set_req(3, 32'h2000_0003, 8'd2);
        issue_one(2);
        issue_one(0);
        issue_one(3);
        beat_log.delete();
        m_rvalid   = 1'b1;
        m_rlast    = 1'b0;
        req_rready = 4'b1011;
        #1;
        chk("stall_m_rready", m_rready, 0);
        chk("stall_req_rvalid", req_rvalid, 4'b0100);
        step(2);
        m_rvalid   = 1'b0;
        req_rready = '1;
        drain_all();
        exp_beats = '{2, 2, 0, 3, 3, 3};
        chk("steer_beats", beat_log.size(), 6);
        if (beat_log.size() == 6)
            for (int k = 0; k < 6; k++) chk("steer_order", beat_log[k], exp_beats[k]);

        // Requesters 0 and 3 both valid; rr now at 0
`ifdef EASYAXI_AR_ARB_FIXED_PRIO_EN
        exp_pri = '{0, 0, 0, 0, 3};
`else
        exp_pri = '{0, 3, 0, 3, 3};
`endif
        base = grant_log.size();
        req_arvalid = 4'b1001;
        step(8);
        req_arvalid = 4'b1000;
        step(1);
        req_arvalid = '0;
        step(1);
        chk("prio_grants", grant_log.size() - base, 5);
        if (grant_log.size() >= base + 5)
            for (int k = 0; k < 5; k++) chk("prio_order", grant_log[base+k], exp_pri[k]);
        drain_all();

        // Reset in the middle of a HOLD with a burst outstanding
        issue_one(2);
        m_arready = 1'b0;
        issue_one(1);
        chk("pre_rst_hold", m_arvalid, 1);
        #3;
        m_rvalid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_m_arvalid", m_arvalid, 0);
        chk("mid_rst_m_araddr", m_araddr, 0);
        chk("mid_rst_m_arlen", m_arlen, 0);
        chk("mid_rst_ost_full", ost_full, 0);
        chk("mid_rst_m_rready", m_rready, 0);
        chk("mid_rst_req_rvalid", req_rvalid, 0);
        step(1);
        m_rvalid = 1'b0;
        rst_n    = 1'b1;
        m_arready = 1'b1;
        base = grant_log.size();
        req_arvalid = 4'b1111;
        step(1);
        req_arvalid = '0;
        chk("post_rst_grant", grant_log.size() - base, 1);
        if (grant_log.size() > base) chk("post_rst_rr0", grant_log[base], 0);
        step(1);
        drain_all();
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
